// File: rtl/test_data_checker.sv
// rtl/test_data_checker.sv - stream pattern checker with lock, counters and first-error capture (optional LFSR pattern: TEST_DATA_CHECKER_LFSR_EN)
module test_data_checker #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CNT_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 32'h8020_0003
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  mode,
    output logic                  locked,
    output logic                  error_flag,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [CNT_WIDTH-1:0]  first_err_index,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic [DATA_WIDTH-1:0] first_err_expected
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    state_t                state;
    state_t                state_nxt;
    state_t                state_eff;
    logic                  hs;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [DATA_WIDTH-1:0] seed_next;
    logic [DATA_WIDTH-1:0] exp_next;
    logic                  mismatch;

    // Ready depends only on the control inputs, so the stream never sees a bubble
    // when enable rises; reset also holds it low.
    assign s_ready  = enable && !clear && !axi_reset;
    assign hs       = s_valid && s_ready;
    assign mismatch = (s_data != exp_q);

`ifdef TEST_DATA_CHECKER_LFSR_EN
    logic mode_q;

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] x);
        return {x[DATA_WIDTH-2:0], ^(x & LFSR_TAPS)};
    endfunction

    assign seed_next = mode   ? lfsr_step(s_data) : s_data + DATA_ONE;
    assign exp_next  = mode_q ? lfsr_step(exp_q)  : exp_q + DATA_ONE;

    // Pattern selection is latched at lock time so mode changes mid-run are ignored.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            mode_q <= 1'b0;
        end else if (clear) begin
            mode_q <= 1'b0;
        end else if (hs && state_eff == ARM) begin
            mode_q <= mode;
        end
    end
`else
    logic unused_cfg;

    assign seed_next  = s_data + DATA_ONE;
    assign exp_next   = exp_q + DATA_ONE;
    assign unused_cfg = ^{mode, LFSR_TAPS};
`endif

    // State register.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a handshake taken in the IDLE cycle where enable rises is
    // handled as the state IDLE is about to resume (ARM, or CHECK if locked).
    always_comb begin
        state_eff = state;
        state_nxt = state;
        if (state == IDLE) begin
            state_eff = locked ? CHECK : ARM;
        end
        if (clear) begin
            state_nxt = enable ? ARM : IDLE;
        end else if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state_eff)
                ARM:     state_nxt = hs ? CHECK : ARM;
                CHECK:   state_nxt = CHECK;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Prediction register, counters, sticky flag and first-mismatch capture.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            exp_q              <= '0;
            locked             <= 1'b0;
            error_flag         <= 1'b0;
            word_count         <= '0;
            error_count        <= '0;
            first_err_index    <= '0;
            first_err_data     <= '0;
            first_err_expected <= '0;
        end else if (clear) begin
            exp_q              <= '0;
            locked             <= 1'b0;
            error_flag         <= 1'b0;
            word_count         <= '0;
            error_count        <= '0;
            first_err_index    <= '0;
            first_err_data     <= '0;
            first_err_expected <= '0;
        end else if (hs) begin
            if (state_eff == ARM) begin
                exp_q  <= seed_next;
                locked <= 1'b1;
            end else begin
                exp_q <= exp_next;
                if (word_count != '1) begin
                    word_count <= word_count + CNT_ONE;
                end
                if (mismatch) begin
                    error_flag <= 1'b1;
                    if (error_count != '1) begin
                        error_count <= error_count + CNT_ONE;
                    end
                    // The sticky flag doubles as the "already captured" marker.
                    if (!error_flag) begin
                        first_err_index    <= word_count;
                        first_err_data     <= s_data;
                        first_err_expected <= exp_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_test_data_checker.sv
// tb/tb_test_data_checker.sv - directed self-checking bench for test_data_checker
module tb_test_data_checker;

    logic        axi_clk;
    logic        axi_reset;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        enable;
    logic        clear;
    logic        mode;
    logic        locked;
    logic        error_flag;
    logic [31:0] word_count;
    logic [31:0] error_count;
    logic [31:0] first_err_index;
    logic [31:0] first_err_data;
    logic [31:0] first_err_expected;

    logic        sat_ready;
    logic        sat_locked;
    logic        sat_error_flag;
    logic [2:0]  sat_word_count;
    logic [2:0]  sat_error_count;
    logic [2:0]  sat_first_err_index;
    logic [31:0] sat_first_err_data;
    logic [31:0] sat_first_err_expected;

    int passed = 0;
    int total  = 0;

    test_data_checker #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .axi_clk            (axi_clk),
        .axi_reset          (axi_reset),
        .s_data             (s_data),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .enable             (enable),
        .clear              (clear),
        .mode               (mode),
        .locked             (locked),
        .error_flag         (error_flag),
        .word_count         (word_count),
        .error_count        (error_count),
        .first_err_index    (first_err_index),
        .first_err_data     (first_err_data),
        .first_err_expected (first_err_expected)
    );

    test_data_checker #(.DATA_WIDTH(32), .CNT_WIDTH(3)) dut_sat (
        .axi_clk            (axi_clk),
        .axi_reset          (axi_reset),
        .s_data             (s_data),
        .s_valid            (s_valid),
        .s_ready            (sat_ready),
        .enable             (enable),
        .clear              (clear),
        .mode               (mode),
        .locked             (sat_locked),
        .error_flag         (sat_error_flag),
        .word_count         (sat_word_count),
        .error_count        (sat_error_count),
        .first_err_index    (sat_first_err_index),
        .first_err_data     (sat_first_err_data),
        .first_err_expected (sat_first_err_expected)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Starts at a negedge, holds the word until accepted, returns at the following negedge.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        s_data  = w;
        s_valid = 1'b1;
        #1;
        while (!s_ready && n < 16) begin
            @(negedge axi_clk);
            #1;
            n++;
        end
        if (n == 16) chk("send_timeout", {63'd0, s_ready}, 64'd1);
        @(posedge axi_clk);
        @(negedge axi_clk);
    endtask

    task automatic pulse_clear();
        s_valid = 1'b0;
        clear   = 1'b1;
        @(negedge axi_clk);
        clear   = 1'b0;
    endtask

    function automatic logic [31:0] lfsr(input logic [31:0] x);
        logic [31:0] taps;
        taps = 32'h8020_0003;
        return {x[30:0], ^(x & taps)};
    endfunction

    initial begin
        logic [31:0] x;
        axi_reset = 1'b1;
        s_data    = '0;
        s_valid   = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        mode      = 1'b0;
        x         = '0;
        repeat (3) @(negedge axi_clk);

        chk("rst_ready",  {63'd0, s_ready}, 64'd0);
        chk("rst_locked", {63'd0, locked}, 64'd0);
        chk("rst_eflag",  {63'd0, error_flag}, 64'd0);
        chk("rst_wc",     {32'd0, word_count}, 64'd0);
        chk("rst_ec",     {32'd0, error_count}, 64'd0);
        chk("rst_fidx",   {32'd0, first_err_index}, 64'd0);
        chk("rst_fdata",  {32'd0, first_err_data}, 64'd0);
        chk("rst_fexp",   {32'd0, first_err_expected}, 64'd0);
        axi_reset = 1'b0;
        @(negedge axi_clk);
        #1;
        chk("dis_ready0", {63'd0, s_ready}, 64'd0);
        @(negedge axi_clk);

        // Clean counter stream 0x10..0x19.
        enable = 1'b1;
        for (int i = 0; i < 10; i++) send(32'h10 + i);
        s_valid = 1'b0;
        chk("cnt_locked", {63'd0, locked}, 64'd1);
        chk("cnt_wc",     {32'd0, word_count}, 64'd9);
        chk("cnt_ec",     {32'd0, error_count}, 64'd0);
        chk("cnt_eflag",  {63'd0, error_flag}, 64'd0);
        chk("sat_wc",     {61'd0, sat_word_count}, 64'd7);

        // Single corrupted word, then a second error that must not overwrite the capture.
        pulse_clear();
        chk("clr_wc",     {32'd0, word_count}, 64'd0);
        chk("clr_locked", {63'd0, locked}, 64'd0);
        send(32'd5); send(32'd6); send(32'd7); send(32'hAA); send(32'd9); send(32'd10);
        s_valid = 1'b0;
        chk("err_ec",    {32'd0, error_count}, 64'd1);
        chk("err_wc",    {32'd0, word_count}, 64'd5);
        chk("err_eflag", {63'd0, error_flag}, 64'd1);
        chk("err_fidx",  {32'd0, first_err_index}, 64'd2);
        chk("err_fdata", {32'd0, first_err_data}, 64'hAA);
        chk("err_fexp",  {32'd0, first_err_expected}, 64'd8);
        send(32'h55);
        s_valid = 1'b0;
        chk("err2_ec",    {32'd0, error_count}, 64'd2);
        chk("err2_fdata", {32'd0, first_err_data}, 64'hAA);
        chk("err2_fexp",  {32'd0, first_err_expected}, 64'd8);

        // Wrap through all-ones.
        pulse_clear();
        chk("clr2_eflag", {63'd0, error_flag}, 64'd0);
        chk("clr2_fdata", {32'd0, first_err_data}, 64'd0);
        chk("clr2_ec",    {32'd0, error_count}, 64'd0);
        send(32'hFFFF_FFFE); send(32'hFFFF_FFFF); send(32'd0); send(32'd1);
        s_valid = 1'b0;
        chk("wrap_wc", {32'd0, word_count}, 64'd3);
        chk("wrap_ec", {32'd0, error_count}, 64'd0);

        // Clear coinciding with a valid word.
        s_data  = 32'h50;
        s_valid = 1'b1;
        clear   = 1'b1;
        #1;
        chk("clrv_ready", {63'd0, s_ready}, 64'd0);
        @(negedge axi_clk);
        clear = 1'b0;
        chk("clrv_wc",     {32'd0, word_count}, 64'd0);
        chk("clrv_locked", {63'd0, locked}, 64'd0);
        send(32'h50);
        chk("relock", {63'd0, locked}, 64'd1);
        send(32'h51); send(32'h52); send(32'h53);
        chk("relock_wc", {32'd0, word_count}, 64'd3);
        chk("relock_ec", {32'd0, error_count}, 64'd0);

        // Enable dropped for four cycles mid-stream.
        enable  = 1'b0;
        s_data  = 32'h54;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("dis_ready", {63'd0, s_ready}, 64'd0);
            @(negedge axi_clk);
        end
        chk("dis_wc",     {32'd0, word_count}, 64'd3);
        chk("dis_locked", {63'd0, locked}, 64'd1);
        enable = 1'b1;
        send(32'h54); send(32'h55);
        s_valid = 1'b0;
        chk("resume_wc", {32'd0, word_count}, 64'd5);
        chk("resume_ec", {32'd0, error_count}, 64'd0);

`ifdef TEST_DATA_CHECKER_LFSR_EN
        // LFSR pattern from seed 1, 20 good successors, then one flipped bit.
        mode = 1'b1;
        pulse_clear();
        x = 32'd1;
        send(x);
        for (int i = 0; i < 20; i++) begin
            x = lfsr(x);
            send(x);
        end
        x = lfsr(x);
        send(x ^ 32'h1);
        s_valid = 1'b0;
        mode    = 1'b0;
        chk("lfsr_ec", {32'd0, error_count}, 64'd1);
        chk("lfsr_wc", {32'd0, word_count}, 64'd21);
`endif

        // Asynchronous reset in the middle of a stream.
        s_data  = 32'h56;
        s_valid = 1'b1;
        #2;
        axi_reset = 1'b1;
        #1;
        chk("arst_wc",     {32'd0, word_count}, 64'd0);
        chk("arst_locked", {63'd0, locked}, 64'd0);
        chk("arst_ready",  {63'd0, s_ready}, 64'd0);
        @(negedge axi_clk);
        axi_reset = 1'b0;
        s_valid   = 1'b0;
        @(negedge axi_clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/test_data_checker.md
# test_data_checker

Stream sink downstream of `test_data_source`. Accepts its DATA_WIDTH-bit valid/ready word stream, locks onto the first word, predicts each following word (incrementing counter, or LFSR when compiled in), and counts words and mismatches. It also captures the first mismatch for readback through the neighbouring AXI-lite register interface. It is the checking half of the source/checker loopback used for link and firmware bring-up.

## Interface
Parameters:
- `DATA_WIDTH`, 32: stream word width, 8..64.
- `CNT_WIDTH`, 32: width of the word and error counters.
- `LFSR_TAPS`, 32'h8020_0003: feedback tap mask, DATA_WIDTH bits; used only with the LFSR build.

Ports:
- `axi_clk` in 1: the only clock.
- `axi_reset` in 1: asynchronous, active-high reset.
- `s_data` in DATA_WIDTH: stream word.
- `s_valid` in 1: word valid.
- `s_ready` out 1: checker ready.
- `enable` in 1: level; run the checker.
- `clear` in 1: single-cycle pulse; zero status and re-arm.
- `mode` in 1: 0 = counter pattern, 1 = LFSR pattern (LFSR build only).
- `locked` out 1: first word has been received.
- `error_flag` out 1: sticky; at least one mismatch seen.
- `word_count` out CNT_WIDTH: accepted words checked while locked.
- `error_count` out CNT_WIDTH: mismatching words.
- `first_err_index` out CNT_WIDTH: `word_count` value at the first mismatch.
- `first_err_data` out DATA_WIDTH: received word at the first mismatch.
- `first_err_expected` out DATA_WIDTH: predicted word at the first mismatch.

## Operation
- A handshake is `s_valid && s_ready`. `s_ready` is combinational: `enable && !clear`. `s_data` is ignored when there is no handshake.
- Next-value function `nxt(x)`:
  - counter mode: `x + 1` mod 2^DATA_WIDTH, so all-ones wraps to 0;
  - LFSR mode: `{x[W-2:0], ^(x & LFSR_TAPS)}`.
- State machine with register `exp`:
  - IDLE: `s_ready` = 0; all status held. `enable` = 1 → ARM.
  - ARM: first handshake loads `exp <= nxt(s_data)`, sets `locked`, and goes to CHECK. This word is not counted or compared.
  - CHECK: each handshake increments `word_count`.
    - If `s_data != exp`: increment `error_count` and set `error_flag`. If this is the first error, capture index/data/expected.
    - `exp <= nxt(exp)` in every case. There is no resync; a dropped word produces continuous errors.
  - `enable` = 0 in any state → IDLE next cycle. `locked` and counters are held.
  - Re-entering from IDLE goes to CHECK if `locked`, otherwise to ARM.
- `clear`, which has priority over everything:
  - zeros all counters, capture registers, `error_flag` and `locked`;
  - moves to ARM if `enable`, otherwise to IDLE;
  - `s_ready` = 0 during that cycle, so no word is lost silently.
- Both counters saturate at all-ones and do not wrap. Capture registers are written only once per clear/reset.
- LFSR mode: an all-zero seed word locks as all-zero; the checker does not correct for this. `mode` is sampled only in ARM; changing it in CHECK has no effect until re-arm.

## Timing
- Reset values: state IDLE; `s_ready` 0 (enable-gated, so also 0 whenever `enable` is 0); every other output 0; `exp` 0.
- Status outputs are registered and update on the edge that completes the handshake: visible 1 cycle after.
- Throughput: one word per cycle sustained. Back-pressure arises only from `enable`/`clear`.
- Reset mid-stream: everything returns to reset values immediately (asynchronous). Release is synchronous to `axi_clk` (synchronised deassert is external).

## Configuration
- Macro `TEST_DATA_CHECKER_LFSR_EN`.
  - Defined: LFSR next-value path and the `mode` input are functional.
  - Undefined: `mode` is ignored, the counter pattern is always used, and the LFSR logic and `LFSR_TAPS` are unused/removed.

## Test plan
- Counter stream 0x10..0x19 (10 words, back-to-back) → `locked` = 1, `word_count` = 9, `error_count` = 0, `error_flag` = 0.
- Counter stream 5,6,7,0xAA,9,10 → `error_count` = 1; `first_err_index` = 2, `first_err_data` = 0xAA, `first_err_expected` = 8.
- Stream 0xFFFF_FFFE, 0xFFFF_FFFF, 0, 1 → no errors; wrap accepted; `word_count` = 3.
- `clear` pulsed on the same cycle as `s_valid` with word 0x50 → `s_ready` = 0 that cycle, all status 0, state ARM; the next word 0x50 relocks with no error.
- `enable` dropped for 4 cycles mid-stream, then the stream resumes in sequence → `s_ready` = 0 while disabled, counts held, no errors on resume.
- LFSR build, `mode` = 1, seed 0x0000_0001 followed by 20 correct successors, then one flipped bit → `error_count` = 1, `word_count` = 21.
